// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the RAM port arbiter.
// Default geometry: 4 requesters sharing one port of a 64x8 RAM.
package ram_port_arbiter_pkg;
  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 6;
  localparam int DW_DEF   = 8;

  typedef enum logic {
    ARB    = 1'b0,
    RD_RSP = 1'b1
  } state_t;

  // Width of a requester index; at least 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester/RAM bundle for ram_port_arbiter.
//   master : requester + RAM side (drives requests and ram_rdata)
//   slave  : arbiter side (drives grants, responses and RAM port)
// Packed fields: requester i at req_addr[i*AW +: AW], req_wdata[i*DW +: DW].
interface ram_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_grant;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_wdata;
  logic               ram_wr;
  logic [DW-1:0]      ram_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_rdata,
    input  req_grant, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_wr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
    output req_grant, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_wr
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Winner selection for ram_port_arbiter.
//   valid : request vector
//   ptr   : round-robin start index
//   grant : one-hot winner (zero when nothing valid)
//   idx   : binary winner index
//   any   : some request is valid
// Macro ARB_FIXED_PRI_EN: fixed priority, index 0 highest, ptr ignored.
module rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  assign any = |valid;

`ifdef ARB_FIXED_PRI_EN
  // Scan downward so the lowest valid index is the last (winning) write.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        grant = '0;
        grant[i] = 1'b1;
        idx = IW'(i);
      end
    end
  end
`else
  // First valid index at or above ptr, wrapping past NREQ-1 to 0.
  always_comb begin
    logic found;
    int   j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
`endif
endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NREQ requesters onto a single registered-output RAM port.
// Writes complete in the grant cycle; reads occupy the port for the grant
// cycle plus one response cycle (RD_RSP) in which ram_rdata is returned.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ram_port_arbiter_if.slave (requests, grants, responses, RAM)
// Macro ARB_FIXED_PRI_EN: fixed priority (requester 0 highest), ptr held at 0.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input logic clk,
  input logic rst,
  ram_port_arbiter_if.slave bus
);
  localparam int IW = idx_w(NREQ);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   id;
  logic [NREQ-1:0] pick_valid, pick_grant;
  logic [IW-1:0]   win;
  logic            any;
  logic            win_we;

  // Arbitration only happens in ARB and never while reset is asserted.
  assign pick_valid = (state == ARB && !rst) ? bus.req_valid : '0;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid (pick_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (win),
    .any   (any)
  );

  assign win_we = bus.req_we[win];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= '0;
      id    <= '0;
    end else begin
      state <= state_nxt;
      if (any) begin
`ifdef ARB_FIXED_PRI_EN
        ptr <= '0;
`else
        ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
        if (!win_we) id <= win;
      end
    end
  end

  // Next state: a granted read parks the port for one response cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (any && !win_we) state_nxt = RD_RSP;
      RD_RSP:  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_grant = pick_grant;
    bus.ram_wr    = any && win_we;
    bus.ram_addr  = any ? bus.req_addr[int'(win)*AW +: AW] : '0;
    bus.ram_wdata = (any && win_we) ? bus.req_wdata[int'(win)*DW +: DW] : '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (state == RD_RSP) begin
      bus.rsp_valid[id] = 1'b1;
      bus.rsp_rdata     = bus.ram_rdata;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
// Honours ARB_FIXED_PRI_EN when defined for the build.
module tb_ram_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered-output RAM behind the port.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ram_q;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    ram_q = '0;
  end
  always @(posedge clk) begin
    if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
    ram_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = ram_q;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester stimulus: each request is held until its grant.
  logic          r_v  [N];
  logic          r_we [N];
  logic [AW-1:0] r_a  [N];
  logic [DW-1:0] r_d  [N];

  // Reference model state.
  logic [DW-1:0] ref_mem [64];
  int            m_ptr = 0;
  int            m_rsp = -1;   // requester owed a read response, -1 none
  logic [DW-1:0] m_rd;

  // Observed DUT outputs of the most recent step.
  logic [N-1:0]  og, orv;
  logic [DW-1:0] ord, owd;
  logic [AW-1:0] oaddr;
  logic          owr;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = r_v[i];
      bus.req_we[i]              = r_we[i];
      bus.req_addr[i*AW +: AW]   = r_a[i];
      bus.req_wdata[i*DW +: DW]  = r_d[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input int a, input int d);
    r_v[i]  = 1'b1;
    r_we[i] = we;
    r_a[i]  = AW'(a);
    r_d[i]  = DW'(d);
    drive();
  endtask

  function automatic int ref_pick();
    int base;
`ifdef ARB_FIXED_PRI_EN
    base = 0;
`else
    base = m_ptr;
`endif
    for (int k = 0; k < N; k++)
      if (r_v[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  // One clock: check outputs at negedge, advance model at posedge,
  // then present the (possibly updated) requests.
  task automatic step();
    int w;
    logic [N-1:0] eg;
    @(negedge clk);
    og = bus.req_grant; orv = bus.rsp_valid; ord = bus.rsp_rdata;
    owd = bus.ram_wdata; oaddr = bus.ram_addr; owr = bus.ram_wr;
    for (int i = 0; i < N; i++)
      assert (bus.req_valid[i] == r_v[i] &&
              (!r_v[i] || (bus.req_addr[i*AW +: AW] == r_a[i] && bus.req_we[i] == r_we[i])))
        else $error("request %0d not held stable", i);
    w = -1;
    if (rst) begin
      chk("rst_grant", og, 0);
      chk("rst_wr", owr, 0);
    end else if (m_rsp >= 0) begin
      chk("rsp_grant", og, 0);
      chk("rsp_wr", owr, 0);
      chk("rsp_valid", orv, 32'(1) << m_rsp);
      chk("rsp_rdata", ord, m_rd);
    end else begin
      w = ref_pick();
      chk("arb_rspv", orv, 0);
      if (w < 0) begin
        chk("idle_grant", og, 0);
        chk("idle_wr", owr, 0);
        chk("idle_addr", oaddr, 0);
        chk("idle_wdata", owd, 0);
      end else begin
        eg = '0; eg[w] = 1'b1;
        chk("grant", og, eg);
        chk("ram_wr", owr, r_we[w]);
        chk("ram_addr", oaddr, r_a[w]);
        if (r_we[w]) chk("ram_wdata", owd, r_d[w]);
      end
    end
    @(posedge clk);
    if (rst) begin
      m_rsp = -1;
      m_ptr = 0;
    end else if (m_rsp >= 0) begin
      m_rsp = -1;
    end else if (w >= 0) begin
      if (r_we[w]) ref_mem[r_a[w]] = r_d[w];
      else begin
        m_rsp = w;
        m_rd  = ref_mem[r_a[w]];
      end
`ifdef ARB_FIXED_PRI_EN
      m_ptr = 0;
`else
      m_ptr = (w + 1) % N;
`endif
      r_v[w] = 1'b0;
    end
    #1;
    drive();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    for (int i = 0; i < N; i++) begin
      r_v[i] = 1'b0; r_we[i] = 1'b0; r_a[i] = '0; r_d[i] = '0;
    end
    drive();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_rspv", orv, 0);

    // Single write then read-back from another requester.
    set_req(0, 1'b1, 5, 8'hA5);
    step();
    chk("d_wr_grant", og, 4'b0001);
    chk("d_wr_we", owr, 1'b1);
    chk("d_wr_addr", oaddr, 5);
    chk("d_wr_data", owd, 8'hA5);
    set_req(2, 1'b0, 5, 0);
    step();
    chk("d_rd_grant", og, 4'b0100);
    step();
    chk("d_rd_rspv", orv, 4'b0100);
    chk("d_rd_data", ord, 8'hA5);

    // Wrap: ptr is now 3 with requesters 3 and 0 both pending.
    set_req(3, 1'b1, 9, 8'h33);
    set_req(0, 1'b1, 10, 8'h44);
    step();
`ifndef ARB_FIXED_PRI_EN
    chk("d_wrap_first", og, 4'b1000);
    step();
    chk("d_wrap_second", og, 4'b0001);
`else
    chk("d_fix_first", og, 4'b0001);
    step();
    chk("d_fix_second", og, 4'b1000);
`endif

    // Preload 0..3 through requester 3, then all four read together.
    for (int k = 0; k < 4; k++) begin
      set_req(3, 1'b1, k, 8'h10 + k);
      step();
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("d_all_grant", og, 32'(1) << k);
      step();
      chk("d_all_rspv", orv, 32'(1) << k);
      chk("d_all_data", ord, 8'h10 + k);
    end

`ifdef ARB_FIXED_PRI_EN
    // Requester 0 keeps winning while it stays valid.
    set_req(1, 1'b1, 20, 8'h01);
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 21 + k, 8'h02);
      step();
      chk("d_fix_hog", og, 4'b0001);
    end
    step();
`endif

    // Reset during a read response drops it; arbitration restarts at 0.
    set_req(1, 1'b0, 2, 0);
    step();
    chk("d_rst_rdgrant", og, 4'b0010);
    set_req(2, 1'b1, 7, 8'h77);
    rst = 1'b1;
    step();
    chk("d_rst_hold_grant", og, 0);
    chk("d_rst_hold_wr", owr, 0);
    rst = 1'b0;
    set_req(1, 1'b0, 3, 0);
    set_req(3, 1'b0, 1, 0);
    step();
    chk("d_post_rst_rspv", orv, 0);
    chk("d_post_rst_grant", og, 4'b0010);
    for (int k = 0; k < 8; k++) step();

    // Randomized traffic over a small address window to force reuse.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!r_v[i] && ($urandom % 3) == 0)
          set_req(i, 1'($urandom % 2), int'($urandom % 8), int'($urandom % 256));
      rst = (($urandom % 150) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, 4, requester count; AW, 6, RAM address width; DW, 8, RAM data width.
REQ-002 clk  input  1  sole clock, all logic on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  NREQ  per-requester access request.
REQ-005 req_we  input  NREQ  per-requester write (1) / read (0).
REQ-006 req_addr  input  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
REQ-007 req_wdata  input  NREQ*DW  packed write data; requester i at [i*DW +: DW].
REQ-008 req_grant  output  NREQ  one-hot acceptance; handshake completes when req_valid[i] & req_grant[i].
REQ-009 rsp_valid  output  NREQ  one-hot read-data strobe.
REQ-010 rsp_rdata  output  DW  read data, valid only when rsp_valid nonzero.
REQ-011 ram_addr  output  AW  to one port of the 64x8 RAM.
REQ-012 ram_wdata  output  DW  to the RAM port.
REQ-013 ram_wr  output  1  RAM port write enable.
REQ-014 ram_rdata  input  DW  registered RAM port output; valid one cycle after a non-write cycle.

Function
REQ-015 FSM SHALL have two states: ARB and RD_RSP.
REQ-016 In ARB, if any req_valid is set, exactly one winner SHALL be granted combinationally in that cycle; otherwise req_grant = 0, ram_wr = 0, ram_addr = 0, ram_wdata = 0.
REQ-017 Winner SHALL be the first valid requester searching upward from round-robin pointer ptr, wrapping NREQ-1 -> 0.
REQ-018 On any grant, ptr SHALL become (winner+1) mod NREQ at the next edge.
REQ-019 Granted write: ram_addr/ram_wdata from the winner, ram_wr = 1 in the grant cycle; FSM stays in ARB; no response is generated.
REQ-020 Granted read: ram_addr from the winner, ram_wr = 0; winner id SHALL be registered and FSM SHALL go to RD_RSP.
REQ-021 In RD_RSP: req_grant = 0, ram_wr = 0, rsp_valid[id] = 1, rsp_rdata = ram_rdata; return to ARB next edge. Read latency is 1 cycle; peak read throughput is 1 per 2 cycles.
REQ-022 Requesters SHALL hold valid/we/addr/wdata stable until granted; the bench SHALL assert this.
REQ-023 All NREQ valid simultaneously: each SHALL be granted once within NREQ grants (no starvation).
REQ-024 Write then read to the same address on consecutive grants SHALL return the new data.

Reset
REQ-025 While rst = 1 at an edge: FSM -> ARB, ptr -> 0, registered id -> 0.
REQ-026 Reset SHALL override RD_RSP mid-operation: the pending response is dropped, and rsp_valid = 0 in the cycle after reset.
REQ-027 While rst is high, req_grant = 0 and ram_wr = 0.

Configuration
REQ-028 With ARB_FIXED_PRI_EN defined: fixed priority, requester 0 highest, and ptr is unused (held at 0).
REQ-029 Without ARB_FIXED_PRI_EN: round-robin per REQ-017/018.

Structure
REQ-030 Shared package SHALL hold the default AW/DW/NREQ constants and the state enumeration (ARB, RD_RSP).
REQ-031 Winner selection SHALL be a sub-module rr_pick (valid vector, ptr in; one-hot grant and binary index out); the macro is honoured there.

Verification
REQ-032 Single write: req0 writes addr 5 data 0xA5 -> grant[0] in the same cycle, ram_wr = 1, ram_addr = 5, ram_wdata = 0xA5.
REQ-033 Read-back: req2 reads addr 5 after the write -> grant[2], then rsp_valid = 0b0100 and rsp_rdata = 0xA5 the next cycle.
REQ-034 All four hold reads (addr 0..3 preloaded 0x10..0x13) -> grant order 0,1,2,3 with rsp 0x10..0x13, 2 cycles each; repeat with ARB_FIXED_PRI_EN -> req0 wins while it stays valid.
REQ-035 Wrap: ptr = 3, req3 and req0 valid -> req3 granted, then req0.
REQ-036 rst asserted during RD_RSP -> rsp_valid = 0 in the next cycle, and the next grant follows ptr = 0.
